accel_dl_detect_unit_timed: RTL

Per-process deadlock detection unit for the HLS dataflow region, with a confirmation window. It propagates dependence vectors and tokens along the channel graph in the same way as the existing unit. A self-dependence (the own PROC_ID bit set in the merged dependence) must persist for CONFIRM_CYCLES consecutive cycles before deadlock is declared, which filters transient back-pressure. On confirmation it latches a sticky flag and the set of blocked output channels for the debug/report path.

---
 rtl/accel_dl_detect_unit_timed.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/accel_dl_detect_unit_timed.sv
// Deadlock detect unit with confirmation window; optional snapshot via DL_DEBUG_CAPTURE_EN.
// Latency: detect asserts CONFIRM_CYCLES cycles after self-dependence first seen; token forward 1 cycle.
// Backpressure: none; blocked-output vector is an input, the unit never stalls its neighbours.
module accel_dl_detect_unit_timed #(
    parameter int PROC_NUM       = 4,
    parameter int PROC_ID        = 0,
    parameter int IN_CHAN_NUM    = 2,
    parameter int OUT_CHAN_NUM   = 3,
    parameter int CONFIRM_CYCLES = 16,
    parameter int CNT_W          = 8
) (
    input  logic                            reset,
    input  logic                            clock,
    input  logic [OUT_CHAN_NUM-1:0]         proc_dep_vld_vec,
    input  logic [IN_CHAN_NUM-1:0]          in_chan_dep_vld_vec,
    input  logic [IN_CHAN_NUM*PROC_NUM-1:0] in_chan_dep_data_vec,
    input  logic [IN_CHAN_NUM-1:0]          token_in_vec,
    input  logic                            dl_detect_in,
    input  logic                            origin,
    input  logic                            token_clear,
    input  logic                            sticky_clr,
    output logic [OUT_CHAN_NUM-1:0]         out_chan_dep_vld_vec,
    output logic [PROC_NUM-1:0]             out_chan_dep_data,
    output logic [OUT_CHAN_NUM-1:0]         token_out_vec,
    output logic                            dl_detect_out,
    output logic                            dl_confirmed,
    output logic [OUT_CHAN_NUM-1:0]         dl_block_vec,
    output logic [PROC_NUM-1:0]             dl_dep_snapshot
);

    localparam logic [PROC_NUM-1:0] SELF_BIT    = {{(PROC_NUM-1){1'b0}}, 1'b1} << PROC_ID;
    localparam logic [CNT_W-1:0]    CONFIRM_VAL = CNT_W'(CONFIRM_CYCLES);

    typedef enum logic [1:0] {IDLE, SUSPECT, CONFIRMED} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_n;
    logic [PROC_NUM-1:0] dep_reg;
    logic [PROC_NUM-1:0] merged;
    logic [PROC_NUM-1:0] dep;
    logic               gate;
    logic               blocked;
    logic               cond;
    logic               enter;

    always_comb begin
        merged = '0;
        for (int i = 0; i < IN_CHAN_NUM; i++) begin
            merged = merged | ({PROC_NUM{in_chan_dep_vld_vec[i]}} &
                               in_chan_dep_data_vec[i*PROC_NUM +: PROC_NUM]);
        end
    end

    // While a global deadlock is flagged, only a token arrival refreshes the dependence.
    assign gate    = ~dl_detect_in | (|token_in_vec);
    assign dep     = gate ? merged : dep_reg;
    assign blocked = |proc_dep_vld_vec;
    assign cond    = gate & dep[PROC_ID] & blocked;
    assign cnt_n   = cnt + 1'b1;
    assign enter   = (state != CONFIRMED) & cond & (cnt_n == CONFIRM_VAL);

    assign out_chan_dep_vld_vec = proc_dep_vld_vec;
    assign out_chan_dep_data    = dep_reg | SELF_BIT;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dep_reg       <= '0;
            token_out_vec <= '0;
        end else begin
            dep_reg <= blocked ? dep : '0;
            if (((|token_in_vec) & ~token_clear) | origin)
                token_out_vec <= proc_dep_vld_vec;
            else
                token_out_vec <= '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            cnt           <= '0;
            dl_detect_out <= 1'b0;
        end else begin
            case (state)
                IDLE, SUSPECT: begin
                    if (cond) begin
                        if (cnt_n == CONFIRM_VAL) begin
                            state         <= CONFIRMED;
                            cnt           <= '0;
                            dl_detect_out <= 1'b1;
                        end else begin
                            state <= SUSPECT;
                            cnt   <= cnt_n;
                        end
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                CONFIRMED: begin
                    if (!blocked) begin
                        state         <= IDLE;
                        dl_detect_out <= 1'b0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    cnt           <= '0;
                    dl_detect_out <= 1'b0;
                end
            endcase
        end
    end

    // A new confirmation outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dl_confirmed <= 1'b0;
            dl_block_vec <= '0;
        end else if (enter) begin
            dl_confirmed <= 1'b1;
            dl_block_vec <= proc_dep_vld_vec;
        end else if (sticky_clr) begin
            dl_confirmed <= 1'b0;
            dl_block_vec <= '0;
        end
    end

`ifdef DL_DEBUG_CAPTURE_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            dl_dep_snapshot <= '0;
        else if (enter)
            dl_dep_snapshot <= dep;
        else if (sticky_clr)
            dl_dep_snapshot <= '0;
    end
`else
    assign dl_dep_snapshot = '0;
`endif

endmodule
